// File: rtl/hbridge_apb_master.sv
// hbridge_apb_master
// APB initiator that converts one motor request into two APB writes to the
// H-bridge peripheral: CMD register (BASE_ADDR) first, then EN register
// (BASE_ADDR+4). A slave error or timeout on the CMD write skips the EN write,
// so the motor is never enabled on a bad direction.
//
// Optional feature: define HBRIDGE_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYCLES consecutive PREADY-low cycles (ERR_CODE=10).
//
// Ports:
//   PCLK, PRESET            clock, async active-high reset
//   REQ_VALID/REQ_READY     request handshake (ready only in IDLE)
//   REQ_CMD, REQ_EN         direction command and enable to write
//   PSEL..PWDATA            APB master outputs (all registered)
//   PREADY, PSLVERR         APB slave response
//   DONE                    one-cycle completion pulse
//   ERR_CODE                00 ok, 01 slave error, 10 timeout
module hbridge_apb_master #(
  parameter logic [15:0] BASE_ADDR      = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [1:0]  REQ_CMD,
  input  logic        REQ_EN,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        DONE,
  output logic [1:0]  ERR_CODE
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TMO_W    = 8;
  localparam logic [DATA_W-1:0] CMD_ADDR = {16'h0000, BASE_ADDR};
  localparam logic [DATA_W-1:0] EN_ADDR  = {16'h0000, 16'(BASE_ADDR + 16'h0004)};
  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_SLV = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  // Reject out-of-range timeout configurations at elaboration.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("hbridge_apb_master: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_SETUP,
    S_CMD_ACCESS,
    S_EN_SETUP,
    S_EN_ACCESS,
    S_FIN
  } state_e;

  state_e state_q;
  // Captured enable; the captured cmd lives in PWDATA for the whole CMD write.
  logic   en_q;

`ifdef HBRIDGE_MASTER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit_c;
  // True on the wait cycle that would make the stall count reach the limit.
  assign tmo_hit_c = ({1'b0, tmo_q} + 9'd1) >= 9'(TIMEOUT_CYCLES);
`endif

  // Single registered FSM: outputs are set for the state being entered.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      REQ_READY <= 1'b1;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      DONE      <= 1'b0;
      ERR_CODE  <= ERR_OK;
`ifdef HBRIDGE_MASTER_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (REQ_VALID) begin
            en_q      <= REQ_EN;
            ERR_CODE  <= ERR_OK;
            REQ_READY <= 1'b0;
            PSEL      <= 1'b1;
            PWRITE    <= 1'b1;
            PADDR     <= CMD_ADDR;
            PWDATA    <= {30'h0, REQ_CMD};
            state_q   <= S_CMD_SETUP;
          end
        end

        S_CMD_SETUP, S_EN_SETUP: begin
          PENABLE <= 1'b1;
`ifdef HBRIDGE_MASTER_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          state_q <= (state_q == S_CMD_SETUP) ? S_CMD_ACCESS : S_EN_ACCESS;
        end

        S_CMD_ACCESS, S_EN_ACCESS: begin
          if (PREADY) begin
            if (PSLVERR) begin
              ERR_CODE <= ERR_SLV;
            end
            if (state_q == S_CMD_ACCESS && !PSLVERR) begin
              PENABLE <= 1'b0;
              PADDR   <= EN_ADDR;
              PWDATA  <= {31'h0, en_q};
              state_q <= S_EN_SETUP;
            end else begin
              PSEL    <= 1'b0;
              PENABLE <= 1'b0;
              PWRITE  <= 1'b0;
              PADDR   <= '0;
              PWDATA  <= '0;
              DONE    <= 1'b1;
              state_q <= S_FIN;
            end
          end
`ifdef HBRIDGE_MASTER_TIMEOUT_EN
          else if (tmo_hit_c) begin
            ERR_CODE <= ERR_TMO;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            DONE     <= 1'b1;
            state_q  <= S_FIN;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
`endif
        end

        S_FIN: begin
          REQ_READY <= 1'b1;
          state_q   <= S_IDLE;
        end

        default: begin
          REQ_READY <= 1'b1;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          PWRITE    <= 1'b0;
          PADDR     <= '0;
          PWDATA    <= '0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hbridge_apb_master.sv
// Testbench for hbridge_apb_master: a transaction-level model expands each
// request into the expected per-cycle bus trace, which is checked cycle by cycle.
module tb_hbridge_apb_master;

  localparam logic [15:0] BASE = 16'h0000;
  localparam int unsigned TMO  = 4;
`ifdef HBRIDGE_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [1:0]  REQ_CMD = 2'b00;
  logic        REQ_EN = 1'b0;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic        DONE;
  logic [1:0]  ERR_CODE;

  hbridge_apb_master #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_CMD(REQ_CMD), .REQ_EN(REQ_EN),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .DONE(DONE), .ERR_CODE(ERR_CODE)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic        ready;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        done;
    logic [1:0]  err;
  } obs_t;

  typedef struct {
    obs_t       exp;
    bit         pready;
    bit         pslverr;
    bit         valid;
    logic [1:0] cmd;
    bit         en;
  } step_t;

  step_t      plan_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] last_err = 2'b00;

  function automatic obs_t sample();
    obs_t o;
    o.ready = REQ_READY; o.psel = PSEL; o.penable = PENABLE; o.pwrite = PWRITE;
    o.paddr = PADDR; o.pwdata = PWDATA; o.done = DONE; o.err = ERR_CODE;
    return o;
  endfunction

  function automatic obs_t idle_obs(input logic [1:0] err);
    obs_t o = '0;
    o.ready = 1'b1;
    o.err   = err;
    return o;
  endfunction

  task automatic push_step(input obs_t e, input bit rdy, input bit serr,
                           input bit v, input logic [1:0] c, input bit n);
    step_t s;
    s.exp = e; s.pready = rdy; s.pslverr = serr; s.valid = v; s.cmd = c; s.en = n;
    plan_q.push_back(s);
  endtask

  // One APB write: a setup cycle, then access cycles until PREADY or timeout.
  task automatic plan_phase(input logic [31:0] addr, input logic [31:0] data,
                            input int waits, input bit serr, input bit v,
                            input logic [1:0] c, input bit n, output logic [1:0] status);
    obs_t e;
    int   cycles;
    bit   timed;
    bit   last;
    e = '0;
    e.psel = 1'b1; e.pwrite = 1'b1; e.paddr = addr; e.pwdata = data;
    push_step(e, 1'($urandom), 1'($urandom), v, c, n);
    timed  = TMO_EN && (waits >= int'(TMO));
    cycles = timed ? int'(TMO) : waits + 1;
    e.penable = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      last = !timed && (k == cycles - 1);
      push_step(e, last, last ? serr : 1'($urandom), v, c, n);
    end
    status = timed ? 2'b10 : (serr ? 2'b01 : 2'b00);
  endtask

  // Whole request: accept cycle, CMD write, EN write unless CMD failed, FIN.
  task automatic plan_req(input logic [1:0] cmd, input bit en, input int wc, input bit ec,
                          input int we, input bit ee, input bit hold);
    logic [1:0] st;
    logic [1:0] vc;
    bit         vn;
    obs_t       e;
    vc = hold ? cmd : 2'($urandom);
    vn = hold ? en : 1'($urandom);
    push_step(idle_obs(last_err), 1'($urandom), 1'($urandom), 1'b1, cmd, en);
    plan_phase({16'h0000, BASE}, {30'h0, cmd}, wc, ec, hold, vc, vn, st);
    if (st == 2'b00)
      plan_phase({16'h0000, 16'(BASE + 16'h0004)}, {31'h0, en}, we, ee, hold, vc, vn, st);
    e = '0;
    e.done = 1'b1;
    e.err  = st;
    push_step(e, 1'($urandom), 1'($urandom), hold, vc, vn);
    last_err = st;
  endtask

  task automatic plan_idle(input int n);
    for (int k = 0; k < n; k++)
      push_step(idle_obs(last_err), 1'($urandom), 1'($urandom), 1'b0, 2'($urandom), 1'($urandom));
  endtask

  task automatic next_cycle(output obs_t got, output obs_t exp);
    step_t s;
    s = plan_q.pop_front();
    @(negedge PCLK);
    got = sample();
    exp = s.exp;
    PREADY = s.pready; PSLVERR = s.pslverr;
    REQ_VALID = s.valid; REQ_CMD = s.cmd; REQ_EN = s.en;
  endtask

  task automatic test_reset();
    obs_t got;
    repeat (2) @(negedge PCLK);
    got = sample();
    vectors++;
    if (got !== idle_obs(2'b00)) begin
      miscompares++;
      $display("FAIL reset got=%h exp=%h", got, idle_obs(2'b00));
    end
    PRESET = 1'b0;
  endtask

  task automatic test_basic();
    obs_t got, exp;
    plan_req(2'b10, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    plan_idle(1);
    for (int i = 0; plan_q.size() > 0; i++) begin
      next_cycle(got, exp);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_wait_cmd();
    obs_t got, exp;
    int   done_cyc = -1;
    plan_req(2'b01, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    plan_idle(1);
    for (int i = 0; plan_q.size() > 0; i++) begin
      next_cycle(got, exp);
      if (got.done && done_cyc < 0) done_cyc = i;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL wait_cmd cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
    vectors++;
    if (done_cyc !== 8) begin
      miscompares++;
      $display("FAIL wait_cmd_done_cycle got=%0d exp=8", done_cyc);
    end
  endtask

  task automatic test_slverr_cmd();
    obs_t got, exp;
    bit   saw_en = 1'b0;
    plan_req(2'b11, 1'b1, 1, 1'b1, 0, 1'b0, 1'b0);
    plan_idle(2);
    for (int i = 0; plan_q.size() > 0; i++) begin
      next_cycle(got, exp);
      if (got.psel && got.paddr == {16'h0000, 16'(BASE + 16'h0004)}) saw_en = 1'b1;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL slverr_cmd cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
    vectors++;
    if (saw_en !== 1'b0) begin
      miscompares++;
      $display("FAIL slverr_cmd_en_issued got=%0b exp=0", saw_en);
    end
  endtask

  task automatic test_slverr_en();
    obs_t got, exp;
    plan_req(2'b01, 1'b1, 0, 1'b0, 2, 1'b1, 1'b0);
    plan_idle(1);
    for (int i = 0; plan_q.size() > 0; i++) begin
      next_cycle(got, exp);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL slverr_en cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    plan_req(2'b10, 1'b1, 0, 1'b0, 3, 1'b0, 1'b0);
    // Steps 0..4: accept, CMD_SETUP, CMD_ACCESS, EN_SETUP, EN_ACCESS.
    for (int i = 0; i < 5; i++) begin
      next_cycle(got, exp);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
    plan_q.delete();
    #2 PRESET = 1'b1;
    #1 got = sample();
    vectors++;
    if (got !== idle_obs(2'b00)) begin
      miscompares++;
      $display("FAIL reset_mid_async got=%h exp=%h", got, idle_obs(2'b00));
    end
    REQ_VALID = 1'b0;
    #1 PRESET = 1'b0;
    last_err = 2'b00;
    plan_idle(1);
    plan_req(2'b01, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    plan_idle(1);
    for (int i = 0; plan_q.size() > 0; i++) begin
      next_cycle(got, exp);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

`ifdef HBRIDGE_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    obs_t got, exp;
    plan_req(2'b10, 1'b1, 0, 1'b0, 20, 1'b0, 1'b0);
    plan_idle(1);
    plan_req(2'b01, 1'b1, 20, 1'b0, 0, 1'b0, 1'b0);
    plan_idle(1);
    plan_req(2'b11, 1'b1, int'(TMO) - 1, 1'b0, int'(TMO) - 1, 1'b0, 1'b0);
    plan_idle(1);
    for (int i = 0; plan_q.size() > 0; i++) begin
      next_cycle(got, exp);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    obs_t got, exp;
    int   accepts = 0;
    for (int r = 0; r < 4; r++)
      plan_req(2'(r), 1'(r), 0, 1'b0, 0, 1'b0, 1'b1);
    plan_idle(1);
    for (int i = 0; plan_q.size() > 0; i++) begin
      next_cycle(got, exp);
      if (got.psel && !got.penable && got.paddr == {16'h0000, BASE}) accepts++;
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
    vectors++;
    if (accepts !== 4) begin
      miscompares++;
      $display("FAIL back_to_back_accepts got=%0d exp=4", accepts);
    end
  endtask

  task automatic test_random();
    obs_t got, exp;
    int   wc, we;
    for (int r = 0; r < 30; r++) begin
      wc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
      we = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
      plan_req(2'($urandom), 1'($urandom), wc, ($urandom_range(0, 5) == 0),
               we, ($urandom_range(0, 5) == 0), 1'($urandom));
      plan_idle(int'($urandom_range(0, 2)));
    end
    plan_idle(1);
    for (int i = 0; plan_q.size() > 0; i++) begin
      next_cycle(got, exp);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_cmd();
    test_slverr_cmd();
    test_reset_mid();
    test_slverr_en();
`ifdef HBRIDGE_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hbridge_apb_master.md
# hbridge_apb_master

APB initiator that turns a single motor request (direction command plus enable) into the two APB write transfers the H-bridge peripheral expects. The CMD register is written first, then the EN register. Sits between the motor-control sequencer logic and the APB fabric on the PCLK domain. Reports completion and bus errors back to the requester.

## Interface
Parameters:
- BASE_ADDR, 16'h0000: H-bridge peripheral base. The CMD register is at BASE_ADDR and the EN register at BASE_ADDR+16'h0004.
- TIMEOUT_CYCLES, 255: maximum consecutive ACCESS cycles with PREADY low. Only used when HBRIDGE_MASTER_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- PCLK  in  1  single clock for the block; all logic is on its rising edge.
- PRESET  in  1  reset, asynchronous and active-high.
- REQ_VALID  in  1  a request is present.
- REQ_READY  out  1  block can accept a request; high only in IDLE.
- REQ_CMD  in  2  direction command to write to the CMD register.
- REQ_EN  in  1  enable value to write to the EN register.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable (ACCESS phase).
- PWRITE  out  1  high while PSEL is high; low otherwise.
- PADDR  out  32  {16'h0, register address}.
- PWDATA  out  32  {30'h0, cmd} for the CMD write; {31'h0, en} for the EN write.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error; sampled only when PENABLE and PREADY are both high.
- DONE  out  1  one-cycle pulse when a request finishes, with or without error.
- ERR_CODE  out  2  result of the last request: 00 ok, 01 slave error, 10 timeout. Held until the next request is accepted.

## Operation
- States: IDLE, CMD_SETUP, CMD_ACCESS, EN_SETUP, EN_ACCESS, FIN.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID, capture REQ_CMD and REQ_EN, clear ERR_CODE to 00, and go to CMD_SETUP.
- CMD_SETUP: PSEL=1, PENABLE=0, PADDR=BASE_ADDR, PWDATA=captured cmd. Always goes to CMD_ACCESS.
- CMD_ACCESS: PSEL=1, PENABLE=1, with address and data held stable.
  - Stays in CMD_ACCESS while PREADY=0.
  - PREADY=1 and PSLVERR=0: go to EN_SETUP.
  - PREADY=1 and PSLVERR=1: ERR_CODE=01, go to FIN. The EN write is not issued, so the motor is never enabled on a bad direction.
- EN_SETUP and EN_ACCESS: same as the CMD pair, with PADDR=BASE_ADDR+4 and PWDATA=captured en.
  - PREADY=1 goes to FIN.
  - PSLVERR at PREADY sets ERR_CODE=01.
- FIN: PSEL=PENABLE=PWRITE=0, DONE=1 for exactly one cycle, then IDLE.
- All APB outputs are registered and change only at state transitions. PADDR and PWDATA return to 0 in IDLE and FIN.
- Requests arriving outside IDLE are not accepted (REQ_READY=0). The requester must hold REQ_VALID and its data until it sees REQ_READY.
- Reset, including reset in the middle of a transfer: all outputs go to 0 immediately, the state returns to IDLE, and the capture registers clear. Any aborted transfer is not resumed.

## Timing
- Reset values: REQ_READY=1; PSEL, PENABLE, PWRITE, PADDR, PWDATA, DONE, ERR_CODE all 0.
- With PREADY held at 1:
  - Accept at edge 0.
  - CMD_SETUP visible in cycle 1, CMD_ACCESS in cycle 2.
  - EN_SETUP in cycle 3, EN_ACCESS in cycle 4.
  - DONE in cycle 5.
  - REQ_READY high again in cycle 6.
- Each PREADY=0 cycle extends the current ACCESS phase by one cycle.
- Back-to-back requests: the minimum spacing between accepts is 6 cycles.

## Configuration
- HBRIDGE_MASTER_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to each ACCESS state and increments on every ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES with PREADY still 0, PSEL and PENABLE drop on the next edge, ERR_CODE=10, and the state goes to FIN.
  - A timeout during the CMD write skips the EN write.
- Not defined: no counter; the block waits indefinitely for PREADY.

## Test plan
- PREADY tied to 1; request cmd=2'b10, en=1 with BASE_ADDR=16'h0000 -> PADDR=0x0 and PWDATA=0x2 in cycles 1–2; PADDR=0x4 and PWDATA=0x1 in cycles 3–4; DONE in cycle 5; ERR_CODE=00.
- PREADY=0 for 3 cycles during CMD_ACCESS -> PENABLE stays high with PADDR and PWDATA stable; DONE arrives 3 cycles later (cycle 8).
- PSLVERR=1 with PREADY on the CMD write -> no transfer to BASE_ADDR+4; DONE one cycle after the CMD access completes; ERR_CODE=01.
- With the macro defined and TIMEOUT_CYCLES=4, PREADY held at 0 on the EN write -> PSEL drops after the timeout expires; DONE pulses; ERR_CODE=10.
- PRESET asserted during EN_ACCESS -> all outputs are 0 in the same cycle and REQ_READY=1 after release; a new request then completes normally.
- REQ_VALID held high continuously -> exactly one accept per 6 cycles; REQ_READY=0 in every non-IDLE cycle.
